// File: rtl/adder_pkg.sv
// Shared width and overflow helpers for the multi-channel streaming adder.
// Kept as constant functions so they can size ports and parameters.
package adder_pkg;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Full sum width: enough headroom that adding n_ch operands never overflows.
  function automatic int fw_f(input int dw, input int n_ch);
    return dw + $clog2(n_ch);
  endfunction

  // Clamp a signed value to the signed range of an ow-bit result.
  function automatic longint sat_f(input longint v, input int ow);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (ow - 1)) - longint'(1);
    lo = -hi - longint'(1);
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/adder_mch_m_if.sv
// Producer-side operand streams and consumer-side sum stream of adder_mch_m.
// The master side drives operands and consumes sums; the slave side is the adder.
interface adder_mch_m_if
  import adder_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int DW   = 16,
  parameter int OW   = fw_f(DW, N_CH)
) ();

  logic [N_CH*DW-1:0] in_data;
  logic [N_CH-1:0]    in_valid;
  logic [N_CH-1:0]    in_ready;
  logic [OW-1:0]      out_data;
  logic               out_valid;
  logic               out_ready;
  logic               ovf;
  logic               ovf_clr;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  ovf,
    output ovf_clr
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output ovf,
    input  ovf_clr
  );

endinterface

// File: rtl/fifo_sc_m.sv
// Single-clock operand FIFO with extra pointer MSB to tell full from empty.
// The head word is read straight out of the storage array so it is usable the cycle after the write.
module fifo_sc_m #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   wr_ptr_d;
  logic [AW:0]   rd_ptr_q;
  logic [AW:0]   rd_ptr_d;
  logic          do_wr;
  logic          do_rd;
  logic [DW-1:0] mem_q [DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Full is judged on registered pointers only, so a full FIFO refuses even while popping.
  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/adder_mch_m.sv
// Multi-channel streaming adder: one FIFO per channel, lock-step pop, adder tree,
// wrap or saturate to OW bits, registered valid/ready output and a sticky overflow flag.
module adder_mch_m
  import adder_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int OW    = fw_f(DW, N_CH),
  parameter int SAT   = SAT_WRAP
) (
  input  logic         clk,
  input  logic         rst,
  adder_mch_m_if.slave bus
);

  localparam int FW = fw_f(DW, N_CH);
  localparam int LV = $clog2(N_CH);
  localparam int NP = 1 << LV;

  logic [N_CH-1:0]      full;
  logic [N_CH-1:0]      empty;
  logic [DW-1:0]        head [N_CH];
  logic                 fire;
  logic signed [FW-1:0] sum_full;
  logic signed [OW-1:0] res;
  logic                 clip;

  logic [OW-1:0] out_data_q;
  logic [OW-1:0] out_data_d;
  logic          out_valid_q;
  logic          out_valid_d;
  logic          ovf_q;
  logic          ovf_d;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    fifo_sc_m #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.in_valid[gi]),
      .wr_data (bus.in_data[gi*DW +: DW]),
      .full    (full[gi]),
      .rd_en   (fire),
      .rd_data (head[gi]),
      .empty   (empty[gi])
    );
  end

  // Balanced tree over NP leaves; channels beyond N_CH are padded with zero.
  for (genvar gl = 0; gl <= LV; gl++) begin : g_lvl
    logic signed [FW-1:0] s [NP >> gl];
    for (genvar gi = 0; gi < (NP >> gl); gi++) begin : g_node
      if (gl == 0) begin : g_leaf
        if (gi < N_CH) begin : g_op
          assign s[gi] = FW'($signed(head[gi]));
        end else begin : g_pad
          assign s[gi] = '0;
        end
      end else begin : g_add
        assign s[gi] = g_lvl[gl-1].s[2*gi] + g_lvl[gl-1].s[2*gi+1];
      end
    end
  end

  assign sum_full = g_lvl[LV].s[0];

  always_comb begin
    if (SAT == SAT_CLAMP) begin
      res = OW'(sat_f(longint'(sum_full), OW));
    end else begin
      res = sum_full[OW-1:0];
    end
    clip = (longint'(res) != longint'(sum_full));
  end

  assign fire = (&(~empty)) && (!out_valid_q || bus.out_ready);

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (fire) begin
      out_data_d  = res;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    // A clip on the same cycle as a clear still leaves the flag set.
    if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (fire && clip) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_adder_mch_m.sv
// Bench for adder_mch_m: a clamping and a wrapping instance share one operand stream;
// a queue model of accepted operands produces expected sums that a negedge monitor compares.
module tb_adder_mch_m;
  import adder_pkg::*;

  localparam int N_CH  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int OW    = 8;

  typedef struct {
    int val;
    bit clip;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_CH*DW-1:0]  in_data;
  logic [N_CH-1:0]     in_valid;
  logic                out_ready;
  logic                ovf_clr;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;
  int   wbuf [N_CH][256];
  int   npush [N_CH];
  int   nsets;
  exp_t exp_a [$];
  exp_t exp_b [$];
  bit   stk_a;
  bit   stk_b;

  always #5 clk = ~clk;

  adder_mch_m_if #(.N_CH(N_CH), .DW(DW), .OW(OW)) ifa ();
  adder_mch_m_if #(.N_CH(N_CH), .DW(DW), .OW(OW)) ifb ();

  assign ifa.in_data   = in_data;
  assign ifa.in_valid  = in_valid;
  assign ifa.out_ready = out_ready;
  assign ifa.ovf_clr   = ovf_clr;
  assign ifb.in_data   = in_data;
  assign ifb.in_valid  = in_valid;
  assign ifb.out_ready = out_ready;
  assign ifb.ovf_clr   = ovf_clr;

  adder_mch_m #(
    .N_CH(N_CH), .DW(DW), .DEPTH(DEPTH), .OW(OW), .SAT(SAT_CLAMP)
  ) u_sat (
    .clk (clk),
    .rst (rst_n),
    .bus (ifa)
  );

  adder_mch_m #(
    .N_CH(N_CH), .DW(DW), .DEPTH(DEPTH), .OW(OW), .SAT(SAT_WRAP)
  ) u_wrap (
    .clk (clk),
    .rst (rst_n),
    .bus (ifb)
  );

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference rules: clamp to [-128,127], or keep the low 8 bits as signed.
  function automatic exp_t mk_sat(input int s);
    exp_t e;
    e.val  = (s > 127) ? 127 : ((s < -128) ? -128 : s);
    e.clip = (e.val != s);
    return e;
  endfunction

  function automatic exp_t mk_wrap(input int s);
    exp_t e;
    int w;
    w = s & 255;
    if (w > 127) w = w - 256;
    e.val  = w;
    e.clip = (w != s);
    return e;
  endfunction

  // Monitor + model: every sum ever produced is the sum of the n-th accepted word of each channel.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) npush[k] = 0;
      nsets = 0;
      exp_a.delete();
      exp_b.delete();
      stk_a = 1'b0;
      stk_b = 1'b0;
    end else begin
      if (ifa.out_valid) begin
        if (exp_a.size() == 0) begin
          chk("sat_spurious_valid", ifa.out_valid, 0);
        end else begin
          chk("sat_data", $signed(ifa.out_data), exp_a[0].val);
          chk("sat_ovf", ifa.ovf, stk_a | exp_a[0].clip);
          if (out_ready) begin
            n_txn++;
            $display("txn %0d: sat out=%0d", n_txn, $signed(ifa.out_data));
            stk_a = stk_a | exp_a[0].clip;
            void'(exp_a.pop_front());
          end
        end
      end else begin
        chk("sat_ovf_idle", ifa.ovf, stk_a);
      end
      if (ifb.out_valid) begin
        if (exp_b.size() == 0) begin
          chk("wrap_spurious_valid", ifb.out_valid, 0);
        end else begin
          chk("wrap_data", $signed(ifb.out_data), exp_b[0].val);
          chk("wrap_ovf", ifb.ovf, stk_b | exp_b[0].clip);
          if (out_ready) begin
            stk_b = stk_b | exp_b[0].clip;
            void'(exp_b.pop_front());
          end
        end
      end else begin
        chk("wrap_ovf_idle", ifb.ovf, stk_b);
      end
      if (ovf_clr) begin
        stk_a = 1'b0;
        stk_b = 1'b0;
      end
      for (int k = 0; k < N_CH; k++) begin
        if (in_valid[k] && ifa.in_ready[k]) begin
          wbuf[k][npush[k] % 256] = int'($signed(in_data[k*DW +: DW]));
          npush[k]++;
        end
      end
      for (int guard = 0; guard < 4; guard++) begin
        bit all_have;
        int s;
        all_have = 1'b1;
        for (int k = 0; k < N_CH; k++) if (npush[k] <= nsets) all_have = 1'b0;
        if (all_have) begin
          s = 0;
          for (int k = 0; k < N_CH; k++) s = s + wbuf[k][nsets % 256];
          nsets++;
          exp_a.push_back(mk_sat(s));
          exp_b.push_back(mk_wrap(s));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk(nm, exp_a.size() + exp_b.size(), 0);
  endtask

  initial begin
    int  cnt;
    bit  acc0;
    int  v;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;

    // Reset state
    tick();
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_data", ifa.out_data, 0);
    chk("rst_ovf", ifb.ovf, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", ifa.in_ready, 4'hF);

    // Latency: 3 + 4 appears two cycles after the push, for one cycle
    in_data  = {8'd0, 8'd0, 8'd4, 8'd3};
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    chk("lat_cycle1_valid", ifa.out_valid, 0);
    tick();
    chk("lat_cycle2_valid", ifa.out_valid, 1);
    chk("lat_cycle2_data", ifb.out_data, 7);
    tick();
    chk("lat_drop_valid", ifa.out_valid, 0);

    // Clamp vs wrap at both extremes, then clear the sticky flag
    in_data  = {4{8'h7F}};
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    tick();
    chk("sat_max_data", ifa.out_data, 8'h7F);
    chk("wrap_max_data", ifb.out_data, 8'hFC);
    chk("sat_max_ovf", ifa.ovf, 1);
    chk("wrap_max_ovf", ifb.ovf, 1);
    tick();
    in_data  = {4{8'h80}};
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    tick();
    chk("sat_min_data", ifa.out_data, 8'h80);
    chk("wrap_min_data", ifb.out_data, 8'h00);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr_sat", ifa.ovf, 0);
    chk("ovf_clr_wrap", ifb.ovf, 0);

    // Ch0 alone fills to DEPTH and holds its 9th word until the others catch up
    for (int i = 0; i < 9; i++) begin
      in_data  = {24'h0, 8'(i + 1)};
      in_valid = 4'b0001;
      @(negedge clk);
      chk("fill_ready_ch0", ifa.in_ready[0], (i < DEPTH) ? 1 : 0);
      chk("fill_ready_ch1", ifa.in_ready[1], 1);
      tick();
    end
    acc0 = 1'b0;
    for (int j = 0; j < 9; j++) begin
      in_data[31:8] = 24'($urandom);
      in_valid[3:1] = 3'b111;
      @(negedge clk);
      if (in_valid[0] && ifa.in_ready[0]) acc0 = 1'b1;
      tick();
      if (acc0) in_valid[0] = 1'b0;
    end
    in_valid = '0;
    chk("ninth_accepted", acc0, 1);
    wait_drain("lockstep_drain");

    // Back-pressure with full FIFOs, then DEPTH+1 sums back-to-back
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_data  = $urandom;
      in_valid = 4'hF;
      tick();
    end
    in_valid = '0;
    @(negedge clk);
    chk("full_ready_sat", ifa.in_ready, 0);
    chk("full_ready_wrap", ifb.in_ready, 0);
    chk("full_out_valid", ifa.out_valid, 1);
    repeat (3) tick();
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!ifa.out_valid) break;
      cnt++;
      tick();
    end
    chk("b2b_count", cnt, DEPTH + 1);
    tick();
    wait_drain("b2b_drain");

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N_CH; k++) begin
        in_valid[k] = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 1) == 1) begin
          in_data[k*DW +: DW] = 8'($urandom);
        end else begin
          v = int'($urandom_range(0, 40)) - 20;
          in_data[k*DW +: DW] = v[7:0];
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    wait_drain("random_drain");

    // Reset mid-stream discards buffered operands and the pending sum
    out_ready = 1'b0;
    in_valid  = 4'hF;
    repeat (5) begin
      in_data = $urandom;
      tick();
    end
    in_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid_sat", ifa.out_valid, 0);
    chk("midrst_out_valid_wrap", ifb.out_valid, 0);
    chk("midrst_out_data", ifa.out_data, 0);
    tick();
    chk("midrst_in_ready", ifa.in_ready, 4'hF);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_stale_sat", ifa.out_valid, 0);
      chk("no_stale_wrap", ifb.out_valid, 0);
    end
    chk("post_rst_in_ready", ifb.in_ready, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
